// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
// Bundles every bus signal between the cache controllers, the arbiter and the
// shared RAM port. Clock and reset stay outside as plain module ports.
//   Cache side : iREN/iaddr, dREN/dWEN/daddr/dstore in;
//                iwait/dwait, iload/dload, ierr/derr out
//   RAM side   : ramREN/ramWEN/ramaddr/ramstore out; ramload/ramstate in
//   Status     : gnt_valid, gnt_id out
// Modports:
//   slave  - the arbiter's view (requests and RAM responses in, the rest out)
//   master - the environment's view (caches + RAM), the mirror image
// ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
interface memory_arbiter_if #(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    localparam int SW = $clog2(2 * CPUS);

    logic [CPUS-1:0]          iREN;
    logic [CPUS-1:0][AW-1:0]  iaddr;
    logic [CPUS-1:0]          dREN;
    logic [CPUS-1:0]          dWEN;
    logic [CPUS-1:0][AW-1:0]  daddr;
    logic [CPUS-1:0][DW-1:0]  dstore;
    logic [CPUS-1:0]          iwait;
    logic [CPUS-1:0]          dwait;
    logic [CPUS-1:0][DW-1:0]  iload;
    logic [CPUS-1:0][DW-1:0]  dload;
    logic                     ramREN;
    logic                     ramWEN;
    logic [AW-1:0]            ramaddr;
    logic [DW-1:0]            ramstore;
    logic [DW-1:0]            ramload;
    logic [1:0]               ramstate;
    logic                     gnt_valid;
    logic [SW-1:0]            gnt_id;
    logic [CPUS-1:0]          ierr;
    logic [CPUS-1:0]          derr;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
        output gnt_valid, gnt_id, ierr, derr
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
        input  gnt_valid, gnt_id, ierr, derr
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Round-robin arbiter between 2*CPUS cache requesters and one shared RAM port.
// Slot 2k is dcache k, slot 2k+1 is icache k. One transaction is granted at a
// time and the grant is held until RAM reports ACCESS or ERROR, or the granted
// slot withdraws its request. Coherence is not handled here.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - memory_arbiter_if.slave carrying all cache and RAM signals
module memory_arbiter #(
    parameter int CPUS = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input logic             CLK,
    input logic             nRST,
    memory_arbiter_if.slave bus
);
    localparam int NS = 2 * CPUS;
    localparam int SW = $clog2(NS);

    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] gnt_id_q, gnt_id_d;
    logic [SW-1:0] last_q, last_d;     // slot that last completed (ACCESS or ERROR)
    logic [NS-1:0] err_q, err_d;       // per-slot error pulse, one cycle after ERROR

    // Per-slot views of the cache request signals
    logic [NS-1:0] req;
    logic [NS-1:0] slot_ren;
    logic [NS-1:0] slot_wen;
    logic [AW-1:0] slot_addr  [NS];
    logic [DW-1:0] slot_store [NS];
    logic [NS-1:0] wait_slot;

    logic          pick_found;
    logic [SW-1:0] pick_id;
    logic [SW-1:0] cand;

    logic          ram_ren;
    logic          ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_store;

    generate
        for (genvar gi = 0; gi < CPUS; gi++) begin : g_cpu
            // data slot
            assign req[2*gi]        = bus.dREN[gi] | bus.dWEN[gi];
            assign slot_ren[2*gi]   = bus.dREN[gi];
            assign slot_wen[2*gi]   = bus.dWEN[gi];
            assign slot_addr[2*gi]  = bus.daddr[gi];
            assign slot_store[2*gi] = bus.dstore[gi];
            // instruction slot (read-only)
            assign req[2*gi+1]        = bus.iREN[gi];
            assign slot_ren[2*gi+1]   = bus.iREN[gi];
            assign slot_wen[2*gi+1]   = 1'b0;
            assign slot_addr[2*gi+1]  = bus.iaddr[gi];
            assign slot_store[2*gi+1] = '0;

            assign bus.dwait[gi] = wait_slot[2*gi];
            assign bus.iwait[gi] = wait_slot[2*gi+1];
            assign bus.derr[gi]  = err_q[2*gi];
            assign bus.ierr[gi]  = err_q[2*gi+1];
            assign bus.iload[gi] = bus.ramload;
            assign bus.dload[gi] = bus.ramload;
        end
    endgenerate

    // Round-robin search: first requesting slot starting at last_q+1, wrapping.
    // Offset NS revisits last_q itself, so a lone requester is always found.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int off = 1; off <= NS; off++) begin
            cand = SW'((int'(last_q) + off) % NS);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        err_d     = '0;
        wait_slot = '1;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_id_d = pick_id;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                ram_addr  = slot_addr[gnt_id_q];
                ram_store = slot_store[gnt_id_q];
                ram_wen   = slot_wen[gnt_id_q];
                // a write wins over a simultaneous read
                ram_ren   = slot_ren[gnt_id_q] & ~slot_wen[gnt_id_q];
                if (!req[gnt_id_q]) begin
                    // abort: no completion, rotation pointer untouched
                    state_d = IDLE;
                end else begin
                    case (bus.ramstate)
                        RAM_ACCESS: begin
                            wait_slot[gnt_id_q] = 1'b0;
                            last_d              = gnt_id_q;
                            state_d             = IDLE;
                        end
                        RAM_ERROR: begin
                            err_d[gnt_id_q] = 1'b1;
                            last_d          = gnt_id_q;
                            state_d         = IDLE;
                        end
                        RAM_FREE, RAM_BUSY: begin
                            state_d = GRANT;
                        end
                        default: begin
                            state_d = GRANT;
                        end
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            gnt_id_q <= '0;
            last_q   <= SW'(NS - 1);   // slot 0 is first after reset
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign bus.ramREN    = ram_ren;
    assign bus.ramWEN    = ram_wen;
    assign bus.ramaddr   = ram_addr;
    assign bus.ramstore  = ram_store;
    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.gnt_id    = gnt_id_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Self-checking bench for memory_arbiter with CPUS=2: a table of single
// transactions, then hand-written abort, error, reset-mid-grant and
// round-robin sequences. Expected grant ids go through a scoreboard queue.
module tb_memory_arbiter;
    localparam int CPUS = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic CLK = 1'b0;
    logic nRST;

    memory_arbiter_if #(.CPUS(CPUS), .AW(AW), .DW(DW)) bus ();

    memory_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int sb[$];

    typedef struct {
        int          slot;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
        int          nbusy;
        logic        err;
        int          exp_id;
        logic        exp_ren;
        logic        exp_wen;
        logic [31:0] exp_addr;
        logic        chk_store;
        logic [31:0] exp_store;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        bus.iREN   = '0;
        bus.iaddr  = '0;
        bus.dREN   = '0;
        bus.dWEN   = '0;
        bus.daddr  = '0;
        bus.dstore = '0;
    endtask

    task automatic set_req(input int slot, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] store);
        int k;
        k = slot / 2;
        if (slot % 2 == 0) begin
            bus.dREN[k]   = ren;
            bus.dWEN[k]   = wen;
            bus.daddr[k]  = addr;
            bus.dstore[k] = store;
        end else begin
            bus.iREN[k]  = ren;
            bus.iaddr[k] = addr;
        end
    endtask

    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            cyc();
            if (bus.gnt_valid === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit              got;
        bit              is_last;
        int              k;
        int              s;
        int              since[4];
        int              budget;
        logic [CPUS-1:0] exp_i;
        logic [CPUS-1:0] exp_d;

        //          slot ren wen addr          store         load          nb err id ren wen exp_addr      chk store
        vecs[0] = '{1,   1,  0,  32'h0000_0040, 32'h0,        32'hDEADBEEF, 2, 0, 1, 1,  0,  32'h0000_0040, 0, 32'h0};
        vecs[1] = '{2,   1,  1,  32'h0000_0100, 32'h12345678, 32'h0,        1, 0, 2, 0,  1,  32'h0000_0100, 1, 32'h12345678};
        vecs[2] = '{0,   1,  0,  32'h0000_0200, 32'hAAAA5555, 32'hCAFEF00D, 0, 0, 0, 1,  0,  32'h0000_0200, 1, 32'hAAAA5555};
        vecs[3] = '{3,   1,  0,  32'h0000_0300, 32'h0,        32'h11112222, 3, 1, 3, 1,  0,  32'h0000_0300, 0, 32'h0};
        vecs[4] = '{0,   0,  1,  32'h0000_0008, 32'h1,        32'h0,        0, 1, 0, 0,  1,  32'h0000_0008, 1, 32'h1};

        clear_req();
        bus.ramstate = RS_FREE;
        bus.ramload  = '0;
        nRST = 1'b0;
        #12;
        check("rst_gnt_valid", bus.gnt_valid, 1'b0);
        check("rst_gnt_id",    bus.gnt_id, 0);
        check("rst_iwait",     bus.iwait, 2'b11);
        check("rst_dwait",     bus.dwait, 2'b11);
        check("rst_ramREN",    bus.ramREN, 1'b0);
        check("rst_ramWEN",    bus.ramWEN, 1'b0);
        check("rst_err",       {bus.ierr, bus.derr}, 4'b0000);
        cyc();
        nRST = 1'b1;

        // ---------------- table-driven single transactions ----------------
        for (int v = 0; v < 5; v++) begin
            k = vecs[v].slot / 2;
            set_req(vecs[v].slot, vecs[v].ren, vecs[v].wen, vecs[v].addr, vecs[v].store);
            bus.ramstate = RS_FREE;
            bus.ramload  = vecs[v].load;
            sb.push_back(vecs[v].exp_id);
            wait_grant(got);
            check("grant_seen", got, 1'b1);
            if (!got) begin
                void'(sb.pop_front());
                clear_req();
                cyc();
            end else begin
                check("gnt_id", bus.gnt_id, sb.pop_front());
                for (int b = 0; b <= vecs[v].nbusy; b++) begin
                    is_last = (b == vecs[v].nbusy);
                    bus.ramstate = !is_last ? RS_BUSY : (vecs[v].err ? RS_ERROR : RS_ACCESS);
                    @(negedge CLK);
                    check("ramREN",  bus.ramREN,  vecs[v].exp_ren);
                    check("ramWEN",  bus.ramWEN,  vecs[v].exp_wen);
                    check("ramaddr", bus.ramaddr, vecs[v].exp_addr);
                    if (vecs[v].chk_store) check("ramstore", bus.ramstore, vecs[v].exp_store);
                    exp_i = '1;
                    exp_d = '1;
                    if (is_last && !vecs[v].err) begin
                        if (vecs[v].slot % 2 == 0) exp_d[k] = 1'b0;
                        else                       exp_i[k] = 1'b0;
                    end
                    check("iwait", bus.iwait, exp_i);
                    check("dwait", bus.dwait, exp_d);
                    if (is_last && !vecs[v].err && vecs[v].exp_ren) begin
                        if (vecs[v].slot % 2 == 0) check("dload", bus.dload[k], vecs[v].load);
                        else                       check("iload", bus.iload[k], vecs[v].load);
                    end
                    cyc();
                end
                check("idle_after_done", bus.gnt_valid, 1'b0);
                exp_i = '0;
                exp_d = '0;
                if (vecs[v].err) begin
                    if (vecs[v].slot % 2 == 0) exp_d[k] = 1'b1;
                    else                       exp_i[k] = 1'b1;
                end
                check("ierr_pulse", bus.ierr, exp_i);
                check("derr_pulse", bus.derr, exp_d);
                clear_req();
                bus.ramstate = RS_FREE;
                cyc();
                check("err_cleared", {bus.ierr, bus.derr}, 4'b0000);
            end
            $display("txn %0d: slot=%0d ren=%0b wen=%0b addr=0x%0h err=%0b", v,
                     vecs[v].slot, vecs[v].ren, vecs[v].wen, vecs[v].addr, vecs[v].err);
        end

        // ---------------- abort: slot 3 drops its request while BUSY ----------------
        // last completion was slot 0
        set_req(3, 1'b1, 1'b0, 32'h3C0, 32'h0);
        bus.ramstate = RS_BUSY;
        wait_grant(got);
        check("abort_grant_seen", got, 1'b1);
        check("abort_gnt_id", bus.gnt_id, 3);
        cyc();
        check("abort_held_busy", bus.gnt_valid, 1'b1);
        set_req(3, 1'b0, 1'b0, 32'h3C0, 32'h0);
        @(negedge CLK);
        check("abort_iwait", bus.iwait, 2'b11);
        check("abort_dwait", bus.dwait, 2'b11);
        cyc();
        check("abort_idle", bus.gnt_valid, 1'b0);
        check("abort_no_err", {bus.ierr, bus.derr}, 4'b0000);
        // rotation pointer still at slot 0, so slot 1 beats slots 3 and 0
        set_req(0, 1'b1, 1'b0, 32'h400, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h404, 32'h0);
        set_req(3, 1'b1, 1'b0, 32'h40C, 32'h0);
        bus.ramstate = RS_ACCESS;
        sb.push_back(1);
        wait_grant(got);
        check("abort_next_seen", got, 1'b1);
        check("abort_next_gnt", bus.gnt_id, sb.pop_front());
        cyc();
        clear_req();
        cyc();
        $display("txn abort: slot 3 aborted, next grant slot %0d", bus.gnt_id);

        // ---------------- error on dcache 0, next grant to slot 1 ----------------
        set_req(0, 1'b1, 1'b0, 32'h500, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h504, 32'h0);
        bus.ramstate = RS_ERROR;
        sb.push_back(0);
        wait_grant(got);
        check("err_grant_seen", got, 1'b1);
        check("err_gnt_id", bus.gnt_id, sb.pop_front());
        @(negedge CLK);
        check("err_dwait", bus.dwait, 2'b11);
        cyc();
        check("err_derr_pulse", bus.derr, 2'b01);
        check("err_ierr_quiet", bus.ierr, 2'b00);
        bus.ramstate = RS_ACCESS;
        sb.push_back(1);
        wait_grant(got);
        check("err_next_seen", got, 1'b1);
        check("err_derr_one_cycle", bus.derr, 2'b00);
        check("err_next_gnt", bus.gnt_id, sb.pop_front());
        @(negedge CLK);
        check("err_next_iwait", bus.iwait, 2'b10);
        check("err_next_dwait", bus.dwait, 2'b11);
        cyc();
        clear_req();
        cyc();
        $display("txn error: slot 0 errored, slot 1 served next");

        // ---------------- reset in the middle of a grant ----------------
        set_req(2, 1'b1, 1'b0, 32'h600, 32'h0);
        bus.ramstate = RS_BUSY;
        wait_grant(got);
        check("rmid_grant_seen", got, 1'b1);
        check("rmid_gnt_id", bus.gnt_id, 2);
        @(negedge CLK);
        check("rmid_ramREN_before", bus.ramREN, 1'b1);
        nRST = 1'b0;
        #1;
        check("rmid_gnt_valid", bus.gnt_valid, 1'b0);
        check("rmid_gnt_id_rst", bus.gnt_id, 0);
        check("rmid_ramREN", bus.ramREN, 1'b0);
        check("rmid_ramaddr", bus.ramaddr, 32'h0);
        check("rmid_waits", {bus.iwait, bus.dwait}, 4'b1111);
        check("rmid_err", {bus.ierr, bus.derr}, 4'b0000);
        for (int sl = 0; sl < 4; sl++) set_req(sl, 1'b1, 1'b0, 32'h700 + 32'(sl * 4), 32'h0);
        bus.ramstate = RS_ACCESS;
        cyc();
        check("rmid_held_in_reset", bus.gnt_valid, 1'b0);
        check("rmid_no_err_pulse", {bus.ierr, bus.derr}, 4'b0000);
        nRST = 1'b1;
        $display("txn reset: dropped grant of slot 2");

        // ---------------- round-robin with all four slots requesting ----------------
        for (int r = 0; r < 8; r++) sb.push_back(r % 4);
        for (int sl = 0; sl < 4; sl++) since[sl] = 0;
        budget = 0;
        while (sb.size() > 0 && budget < 40) begin
            cyc();
            budget++;
            if (bus.gnt_valid === 1'b1) begin
                s = int'(bus.gnt_id);
                check("rr_order", bus.gnt_id, sb.pop_front());
                if (s < 4) begin
                    check("rr_gap_le4", (since[s] <= 4), 1'b1);
                    for (int sl = 0; sl < 4; sl++) since[sl]++;
                    since[s] = 0;
                end
                $display("txn rr: grant slot %0d", s);
            end
        end
        check("rr_all_granted", sb.size(), 0);
        clear_req();
        bus.ramstate = RS_FREE;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Parametrised RAM arbiter between the per-CPU instruction and data caches and the single shared RAM port. It serves `CPUS` processors, each with one instruction and one data requester (2·`CPUS` slots). One transaction at a time is granted round-robin, and the grant is held until RAM completes or errors. It replaces the single-CPU fixed-priority combinational arbiter and sits where that block sat, between the cache controllers and the RAM model. Coherence is not handled here.

## Interface
- `CPUS`, 2, number of processors; slot `2k` is dcache k, slot `2k+1` is icache k.
- `AW`, 32, address width.
- `DW`, 32, data word width.
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`  in  `CPUS`  instruction read request per CPU.
- `iaddr`  in  `CPUS`×`AW`  instruction address per CPU.
- `dREN`  in  `CPUS`  data read request per CPU.
- `dWEN`  in  `CPUS`  data write request per CPU; wins over `dREN` when both are set.
- `daddr`  in  `CPUS`×`AW`  data address per CPU.
- `dstore`  in  `CPUS`×`DW`  write data per CPU.
- `iwait`  out  `CPUS`  1 = instruction request not complete.
- `dwait`  out  `CPUS`  1 = data request not complete.
- `iload`  out  `CPUS`×`DW`  read data; every lane = `ramload`.
- `dload`  out  `CPUS`×`DW`  read data; every lane = `ramload`.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  `AW`  RAM address.
- `ramstore`  out  `DW`  RAM write data.
- `ramload`  in  `DW`  RAM read data.
- `ramstate`  in  2  `ramstate_t` from `cpu_types_pkg` (FREE, BUSY, ACCESS, ERROR).
- `gnt_valid`  out  1  a slot currently holds the grant.
- `gnt_id`  out  clog2(2·`CPUS`)  granted slot index.
- `ierr`  out  `CPUS`  one-cycle pulse: instruction transaction ended in ERROR.
- `derr`  out  `CPUS`  one-cycle pulse: data transaction ended in ERROR.

## Operation
- Slot request: `req[2k] = dREN[k] | dWEN[k]`; `req[2k+1] = iREN[k]`.
- FSM states:
  - IDLE
    - Any `req` set: pick the first set slot scanning from `last+1` upward, modulo 2·`CPUS`.
    - Register it as `gnt_id`, go to GRANT.
    - No request: stay in IDLE.
  - GRANT
    - Drive RAM from the granted slot: `ramaddr` = that slot's address, `ramstore` = `dstore` (data slots), `ramWEN` = `dWEN` (data slots), `ramREN` = the slot's read request and not `ramWEN`.
    - `ramstate` ACCESS: clear that slot's wait this cycle, set `last` = `gnt_id`, go to IDLE.
    - `ramstate` ERROR: keep wait = 1, pulse the slot's `ierr`/`derr` next cycle, set `last` = `gnt_id`, go to IDLE.
    - Granted slot drops its request (abort): go to IDLE with no completion, `last` unchanged.
    - FREE or BUSY: stay in GRANT.
- Outputs outside GRANT: `ramREN` = `ramWEN` = 0, `ramaddr` = 0, `ramstore` = 0.
- `iwait`/`dwait`: 1 for every slot except the granted slot in its ACCESS cycle.
- A CPU's data and instruction slots are independent requesters; a CPU can have both pending.
- Round-robin guarantee: a continuously asserted request is granted within 2·`CPUS` grants.

## Timing
- Reset state (asynchronous, `nRST` low):
  - FSM in IDLE, `last` = 2·`CPUS`−1 so slot 0 is first after reset.
  - `gnt_valid` = 0, `gnt_id` = 0, `ierr`/`derr` = 0.
  - All waits 1, RAM enables 0.
- Reset mid-GRANT: the transaction is dropped immediately, with no completion and no error pulse.
- Latency: request seen in IDLE at cycle t → RAM enables asserted at t+1 → wait low in the first ACCESS cycle (t+1 at the earliest) → IDLE at the next edge.
  - Back-to-back transactions cost one IDLE bubble each.
- Wait is combinational from `ramstate`. Grant and FSM state are registered.
- `gnt_valid` = 1 exactly while in GRANT.
- A request that appears or disappears during another slot's GRANT does not affect that grant.

## Test plan
- Single read, `CPUS`=2: `iREN[0]`=1, `iaddr[0]`=0x40, RAM gives BUSY, BUSY, ACCESS with `ramload`=0xDEADBEEF
  - `ramaddr`=0x40 and `ramREN`=1 from cycle 1.
  - `iwait[0]`=0 only in the ACCESS cycle, with `iload[0]`=0xDEADBEEF.
- Write over read: `dWEN[1]`=`dREN[1]`=1, `daddr[1]`=0x100, `dstore[1]`=0x12345678
  - `ramWEN`=1, `ramREN`=0, `ramstore`=0x12345678.
  - `gnt_id`=2.
- Round-robin: all four slots requesting continuously, RAM always ACCESS
  - Grant order 0,1,2,3,0.
  - No slot waits more than 4 grants.
- Error: `dREN[0]` granted, `ramstate`=ERROR
  - `dwait[0]` stays 1.
  - `derr[0]` pulses for one cycle.
  - Next grant goes to slot 1 if it is requesting.
- Abort: `iREN[1]` granted, then dropped while RAM is BUSY
  - FSM returns to IDLE, no wait drop, `last` unchanged.
- Reset mid-GRANT: `nRST` low during BUSY
  - All outputs take reset values in the same cycle.
  - After release, the first grant goes to slot 0.
